// File: rtl/mode_counter_pkg.sv
// Shared types for the mode counter family: count direction and run mode.
package counter_pkg;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } count_dir_e;

   typedef enum logic {
      MODE_WRAP    = 1'b0,
      MODE_ONESHOT = 1'b1
   } count_mode_e;

endpackage

// File: rtl/mode_counter_if.sv
// Control/status bundle of the mode counter.
// Handshake: there is no valid/ready pair; every control input is sampled on
// each rising clk edge and every status output is valid one edge later
// (top is combinational from val).
interface mode_counter_if
   import counter_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int PRESCALE_WIDTH = 4
);
   logic                      en;
   logic                      load;
   logic [WIDTH-1:0]          load_val;
   count_dir_e                dir;
   count_mode_e               mode;
   logic [WIDTH-1:0]          max;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [WIDTH-1:0]          val;
   logic                      top;
   logic                      wrap_pulse;
   logic                      done;

   modport master (
      output en, load, load_val, dir, mode, max, prescale,
      input  val, top, wrap_pulse, done
   );

   modport slave (
      input  en, load, load_val, dir, mode, max, prescale,
      output val, top, wrap_pulse, done
   );
endinterface

// File: rtl/mode_counter_prescaler.sv
// Programmable prescaler: emits one tick every prescale+1 enabled cycles.
// clr restarts the period; freeze holds psc and suppresses ticks.
module prescaler #(
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      clr,
   input  logic                      freeze,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);
   logic [PRESCALE_WIDTH-1:0] psc;

   // A period ends when the running count reaches the programmed divider.
   assign tick = en && (psc == prescale) && !freeze;

   // Period counter; a lowered prescale simply wraps around before matching.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         psc <= '0;
      end else if (en && !freeze) begin
         psc <= tick ? '0 : psc + 1'b1;
      end
   end
endmodule

// File: rtl/mode_counter.sv
// Up/down counter with prescaler, wrap or one-shot mode, parallel load,
// registered terminal pulse and sticky done flag.
module mode_counter
   import counter_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   mode_counter_if.slave bus
);
   logic             tick;
   logic [WIDTH-1:0] val_q;
   logic             wrap_q;
   logic             done_q;

   prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .en       (bus.en),
      .clr      (bus.load),
      .freeze   (done_q),
      .prescale (bus.prescale),
      .tick     (tick)
   );

   // Count register: reset beats load, load beats tick, otherwise hold.
   // Up-count terminal uses >= so a max lowered below val still wraps at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         val_q  <= '0;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
      end else if (bus.load) begin
         val_q  <= bus.load_val;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (tick) begin
            if (bus.dir == DIR_UP) begin
               if (val_q >= bus.max) begin
                  wrap_q <= 1'b1;
                  if (bus.mode == MODE_WRAP) val_q  <= '0;
                  else                       done_q <= 1'b1;
               end else begin
                  val_q <= val_q + 1'b1;
               end
            end else begin
               if (val_q == '0) begin
                  wrap_q <= 1'b1;
                  if (bus.mode == MODE_WRAP) val_q  <= bus.max;
                  else                       done_q <= 1'b1;
               end else begin
                  val_q <= val_q - 1'b1;
               end
            end
         end
      end
   end

   assign bus.val        = val_q;
   assign bus.top        = (val_q == bus.max);
   assign bus.wrap_pulse = wrap_q;
   assign bus.done       = done_q;
endmodule
